// File: rtl/output_port_ext.sv
// Latched WIDTH-bit output port with write/set/clear/toggle modes and a timed one-shot pulse overlay.
// Optional macro OUTPORT_OUTREG_EN adds a second output register stage on pins_out and busy.
module output_port_ext #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pulse_start,
    input  logic [CNT_W-1:0] pulse_len,
    output logic [WIDTH-1:0] pins_out,
    output logic             busy,
    output logic             wr_drop
);

    typedef enum logic {IDLE, PULSE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shadow, shadow_nxt;
    logic [WIDTH-1:0] pins_int, pins_nxt;
    logic [WIDTH-1:0] wr_val;
    logic [CNT_W-1:0] counter, counter_nxt;
    logic             busy_int, busy_nxt;
    logic             drop_nxt;

    always_comb begin
        case (wr_mode)
            2'b00:   wr_val = data_in;
            2'b01:   wr_val = shadow | data_in;
            2'b10:   wr_val = shadow & ~data_in;
            default: wr_val = shadow ^ data_in;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        shadow_nxt  = shadow;
        pins_nxt    = pins_int;
        counter_nxt = counter;
        busy_nxt    = busy_int;
        drop_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (pulse_start) begin
                    pins_nxt    = data_in;
                    counter_nxt = (pulse_len == '0) ? CNT_W'(1) : pulse_len;
                    busy_nxt    = 1'b1;
                    state_nxt   = PULSE;
                    drop_nxt    = wr_en;
                end else if (wr_en) begin
                    shadow_nxt = wr_val;
                    pins_nxt   = wr_val;
                end
            end
            PULSE: begin
                if (wr_en) begin
                    shadow_nxt = wr_val;
                end
                drop_nxt    = pulse_start;
                counter_nxt = counter - CNT_W'(1);
                // Restore uses the post-write shadow so a write on the last edge is not lost.
                if (counter == CNT_W'(1)) begin
                    pins_nxt  = shadow_nxt;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shadow   <= RESET_VAL;
            pins_int <= RESET_VAL;
            counter  <= '0;
            busy_int <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            state    <= state_nxt;
            shadow   <= shadow_nxt;
            pins_int <= pins_nxt;
            counter  <= counter_nxt;
            busy_int <= busy_nxt;
            wr_drop  <= drop_nxt;
        end
    end

`ifdef OUTPORT_OUTREG_EN
    logic [WIDTH-1:0] pins_q;
    logic             busy_q;

    // busy is delayed with the pins so both stay cycle-aligned at the pad.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pins_q <= RESET_VAL;
            busy_q <= 1'b0;
        end else begin
            pins_q <= pins_int;
            busy_q <= busy_int;
        end
    end

    assign pins_out = pins_q;
    assign busy     = busy_q;
`else
    assign pins_out = pins_int;
    assign busy     = busy_int;
`endif

endmodule

// File: tb/tb_output_port_ext.sv
// Scoreboard bench for output_port_ext: a cycle model pushes expected outputs per edge,
// which are popped and compared at the following falling edge.
module tb_output_port_ext;

    localparam logic [7:0] RST_V = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_mode;
    logic [7:0] data_in;
    logic       pulse_start;
    logic [7:0] pulse_len;
    logic [7:0] pins_out;
    logic       busy;
    logic       wr_drop;

    output_port_ext #(.WIDTH(8), .CNT_W(8), .RESET_VAL(RST_V)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_mode     (wr_mode),
        .data_in     (data_in),
        .pulse_start (pulse_start),
        .pulse_len   (pulse_len),
        .pins_out    (pins_out),
        .busy        (busy),
        .wr_drop     (wr_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pins;
        logic       busy;
        logic       drop;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    logic [7:0] m_shadow = RST_V;
    logic [7:0] m_pins   = RST_V;
    logic [7:0] m_cnt    = 8'd0;
    logic       m_busy   = 1'b0;
    logic       m_drop   = 1'b0;
    logic [7:0] m_pins_d = RST_V;
    logic       m_busy_d = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] apply_mode(input logic [7:0] s, input logic [1:0] m,
                                              input logic [7:0] d);
        case (m)
            2'b00:   return d;
            2'b01:   return s | d;
            2'b10:   return s & ~d;
            default: return s ^ d;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic we, input logic [1:0] m,
                              input logic [7:0] d, input logic ps, input logic [7:0] pl);
        m_pins_d = m_pins;
        m_busy_d = m_busy;
        if (!r) begin
            m_shadow = RST_V; m_pins = RST_V; m_cnt = 0; m_busy = 0; m_drop = 0;
            m_pins_d = RST_V; m_busy_d = 0;
        end else if (!m_busy) begin
            m_drop = 0;
            if (ps) begin
                m_pins = d;
                m_cnt  = (pl == 0) ? 8'd1 : pl;
                m_busy = 1;
                m_drop = we;
            end else if (we) begin
                m_shadow = apply_mode(m_shadow, m, d);
                m_pins   = m_shadow;
            end
        end else begin
            if (we) m_shadow = apply_mode(m_shadow, m, d);
            m_drop = ps;
            if (m_cnt == 1) begin
                m_pins = m_shadow;
                m_busy = 0;
            end
            m_cnt = m_cnt - 8'd1;
        end
    endtask

    task automatic step(input string tag, input logic r, input logic we, input logic [1:0] m,
                        input logic [7:0] d, input logic ps, input logic [7:0] pl);
        exp_t e;
        rst_n = r; wr_en = we; wr_mode = m; data_in = d; pulse_start = ps; pulse_len = pl;
        @(posedge clk);
        model_edge(r, we, m, d, ps, pl);
`ifdef OUTPORT_OUTREG_EN
        exp_q.push_back('{pins: m_pins_d, busy: m_busy_d, drop: m_drop});
`else
        exp_q.push_back('{pins: m_pins, busy: m_busy, drop: m_drop});
`endif
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, ".pins"}, 32'(pins_out), 32'(e.pins));
        check({tag, ".busy"}, 32'(busy), 32'(e.busy));
        check({tag, ".drop"}, 32'(wr_drop), 32'(e.drop));
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step($sformatf("%s%0d", tag, i), 1, 0, 2'b00, 8'h00, 0, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset while a write is presented
        step("rst0", 0, 1, 2'b00, 8'hFF, 0, 8'd0);
        step("rst1", 0, 1, 2'b00, 8'hFF, 0, 8'd0);
        idle("rel", 2);

        // Write modes: 5A, |81=DB, &~0F=D0, ^FF=2F
        step("wr",  1, 1, 2'b00, 8'h5A, 0, 8'd0);
        step("set", 1, 1, 2'b01, 8'h81, 0, 8'd0);
        step("clr", 1, 1, 2'b10, 8'h0F, 0, 8'd0);
        step("tgl", 1, 1, 2'b11, 8'hFF, 0, 8'd0);
        idle("wm", 2);

        // Pulse len 3 then len 0
        step("sh0f", 1, 1, 2'b00, 8'h0F, 0, 8'd0);
        step("p3",   1, 0, 2'b00, 8'hF0, 1, 8'd3);
        idle("p3i", 5);
        step("p0",   1, 0, 2'b00, 8'hF0, 1, 8'd0);
        idle("p0i", 3);

        // Write during pulse
        step("sh00", 1, 1, 2'b00, 8'h00, 0, 8'd0);
        step("p4",   1, 0, 2'b00, 8'hFF, 1, 8'd4);
        idle("p4a", 1);
        step("p4set", 1, 1, 2'b01, 8'h03, 0, 8'd0);
        idle("p4b", 5);

        // Conflicts
        step("cfl",  1, 1, 2'b00, 8'h55, 1, 8'd2);
        idle("cfli", 3);
        step("p5",   1, 0, 2'b00, 8'h33, 1, 8'd5);
        idle("p5a", 1);
        step("retr", 1, 0, 2'b00, 8'hCC, 1, 8'd1);
        idle("p5b", 6);

        // Write on final pulse edge
        step("p2",   1, 0, 2'b00, 8'h81, 1, 8'd2);
        idle("p2a", 1);
        step("p2w",  1, 1, 2'b11, 8'hF0, 0, 8'd0);
        idle("p2b", 3);

        // Reset mid-pulse
        step("pa",   1, 0, 2'b00, 8'hAA, 1, 8'd10);
        idle("paa", 3);
        step("prst", 0, 0, 2'b00, 8'h00, 0, 8'd0);
        idle("pab", 12);

        // Longest pulse
        step("sh3c", 1, 1, 2'b00, 8'h3C, 0, 8'd0);
        step("pmax", 1, 0, 2'b00, 8'hC3, 1, 8'd255);
        idle("pmx", 258);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i),
                 $urandom_range(0, 59) != 0,
                 $urandom_range(0, 2) == 0,
                 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)),
                 $urandom_range(0, 6) == 0,
                 8'($urandom_range(0, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
